// File: rtl/reindeer_csr_access_sequencer_pkg.sv
// Shared constants for the CSR access sequencer: Zicsr funct3 encodings,
// sequencer states and the read-only CSR address field.
package reindeer_csr_access_sequencer_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // funct3[1:0] selects the operation for both register and immediate forms
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [1:0] RO_ADDR_FIELD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_WCHK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/reindeer_csr_rmw_alu.sv
// Read-modify-write value computation for CSRRW/RS/RC and whether the
// result actually has to be written back.
module reindeer_csr_rmw_alu
  import reindeer_csr_access_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_value,
  output logic            write_needed
);

  always_comb begin
    new_value    = src;
    write_needed = 1'b0;
    case (op)
      OP_RW: begin
        new_value    = src;
        write_needed = 1'b1;
      end
      OP_RS: begin
        new_value    = old | src;
        write_needed = |src;
      end
      OP_RC: begin
        new_value    = old & ~src;
        write_needed = |src;
      end
      default: begin
        new_value    = src;
        write_needed = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reindeer_csr_access_sequencer.sv
// Zicsr initiator: sequences read/modify/write on the CSR file port and
// reports unknown-address and read-only-write faults as illegal_instr.
module reindeer_csr_access_sequencer
  import reindeer_csr_access_sequencer_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned CSR_ADDR_BITS = 12,
  parameter int unsigned WAIT_LIMIT    = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [CSR_ADDR_BITS-1:0] csr_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [4:0]               uimm,
  input  logic                     rd_is_x0,
  input  logic                     abort,
  output logic                     csr_read_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
  input  logic                     csr_read_valid,
  input  logic [XLEN-1:0]          csr_read_data,
  input  logic                     csr_fault,
  output logic                     csr_write_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
  output logic [XLEN-1:0]          csr_write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_write_enable,
  output logic [XLEN-1:0]          rd_data,
  output logic                     illegal_instr
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_LIMIT - 1);

  state_t                   state;
  logic [1:0]               op_q;
  logic [CSR_ADDR_BITS-1:0] addr_q;
  logic [XLEN-1:0]          src_q;
  logic                     rd_x0_q;
  logic [XLEN-1:0]          old_q;
  logic [XLEN-1:0]          wdata_q;
  logic                     illegal_q;
  logic                     read_done_q;
  logic [1:0]               wait_cnt;

  logic [XLEN-1:0] src_in;
  logic [XLEN-1:0] alu_new;
  logic            alu_write_needed;
  logic            start_ro;
  logic            latched_ro;

  assign src_in     = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_data;
  assign start_ro   = (csr_addr[CSR_ADDR_BITS-1 -: 2] == RO_ADDR_FIELD);
  assign latched_ro = (addr_q[CSR_ADDR_BITS-1 -: 2] == RO_ADDR_FIELD);

  reindeer_csr_rmw_alu #(
    .XLEN(XLEN)
  ) u_rmw_alu (
    .op          (op_q),
    .old         (csr_read_data),
    .src         (src_q),
    .new_value   (alu_new),
    .write_needed(alu_write_needed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      src_q       <= '0;
      rd_x0_q     <= 1'b0;
      old_q       <= '0;
      wdata_q     <= '0;
      illegal_q   <= 1'b0;
      read_done_q <= 1'b0;
      wait_cnt    <= '0;
    end else if (abort) begin
      state       <= ST_IDLE;
      illegal_q   <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q        <= funct3[1:0];
            addr_q      <= csr_addr;
            src_q       <= src_in;
            rd_x0_q     <= rd_is_x0;
            illegal_q   <= 1'b0;
            read_done_q <= 1'b0;
            if (funct3[1:0] == OP_NONE) begin
              illegal_q <= 1'b1;
              state     <= ST_DONE;
            end else if (funct3[1:0] == OP_RW && rd_is_x0) begin
              // CSRRW to x0 has no side-effecting read, so go straight to the write
              if (start_ro) begin
                illegal_q <= 1'b1;
                state     <= ST_DONE;
              end else begin
                wdata_q <= src_in;
                state   <= ST_WRITE;
              end
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (csr_read_valid) begin
            old_q       <= csr_read_data;
            read_done_q <= 1'b1;
            if (csr_fault) begin
              illegal_q <= 1'b1;
              state     <= ST_DONE;
            end else if (alu_write_needed) begin
              if (latched_ro) begin
                illegal_q <= 1'b1;
                state     <= ST_DONE;
              end else begin
                wdata_q <= alu_new;
                state   <= ST_WRITE;
              end
            end else begin
              state <= ST_DONE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            illegal_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_WRITE: state <= ST_WCHK;
        ST_WCHK: begin
          if (csr_fault) illegal_q <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign csr_read_enable  = (state == ST_READ);
  assign csr_read_addr    = addr_q;
  assign csr_write_enable = (state == ST_WRITE);
  assign csr_write_addr   = addr_q;
  assign csr_write_data   = wdata_q;
  assign busy             = (state != ST_IDLE);
  assign done             = (state == ST_DONE);
  assign rd_write_enable  = done & ~illegal_q & ~rd_x0_q & read_done_q;
  assign rd_data          = old_q;
  assign illegal_instr    = done & illegal_q;

endmodule
